// File: rtl/box_motion_ctrl.sv
// -----------------------------------------------------------------------------
// box_motion_ctrl
// Per-frame motion controller for the bouncing box drawn by the pixel renderer.
// A frame tick is taken from the VGA counters. Each unpaused tick runs a short
// update sequence: X step, Y step, then commit. The host can reposition the box
// with a valid/ready load handshake. Loaded coordinates are clamped into the
// visible area.
//
// Ports
//   clk_25        in   pixel clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   h_count       in   [9:0] horizontal pixel counter
//   v_count       in   [9:0] vertical line counter
//   pause         in   freezes motion while high (frame_cnt still counts)
//   speed         in   [1:0] step per frame = speed+1 pixels
//   load_valid    in   host repositioning request
//   load_x/load_y in   [9:0] requested position
//   load_ready    out  load accepted when load_valid && load_ready
//   box_x/box_y   out  [9:0] box left / top edge
//   dir_right     out  1 = moving right
//   dir_down      out  1 = moving down
//   bounce        out  [1:0] one-cycle pulse, [0] X wall, [1] Y wall
//   update_strobe out  one-cycle pulse after each committed motion update
//   frame_cnt     out  [7:0] frame tick counter
// -----------------------------------------------------------------------------
module box_motion_ctrl #(
    parameter int BOX_W   = 36,
    parameter int BOX_H   = 36,
    parameter int PORCH_L = 144,
    parameter int PORCH_R = 784,
    parameter int PORCH_T = 36,
    parameter int PORCH_B = 500,
    parameter int INIT_X  = 144,
    parameter int INIT_Y  = 36
) (
    input  logic       clk_25,
    input  logic       rst_n,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       pause,
    input  logic [1:0] speed,
    input  logic       load_valid,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    output logic       load_ready,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic       dir_right,
    output logic       dir_down,
    output logic [1:0] bounce,
    output logic       update_strobe,
    output logic [7:0] frame_cnt
);

    localparam logic [9:0] L_MIN_X  = 10'(PORCH_L);
    localparam logic [9:0] L_MIN_Y  = 10'(PORCH_T);
    localparam logic [9:0] L_MAX_X  = 10'(PORCH_R - 1 - BOX_W);
    localparam logic [9:0] L_MAX_Y  = 10'(PORCH_B - 1 - BOX_H);
    localparam logic [9:0] L_INIT_X = 10'(INIT_X);
    localparam logic [9:0] L_INIT_Y = 10'(INIT_Y);

    typedef enum logic [2:0] {IDLE, UPD_X, UPD_Y, COMMIT, LOAD} state_t;

    // One axis step. Returns {hit, new_dir, new_pos}. The comparisons are
    // done in 11 bits so that pos+step cannot wrap.
    function automatic logic [11:0] axis_step(input logic [9:0] pos,
                                              input logic       fwd,
                                              input logic [9:0] step,
                                              input logic [9:0] lo,
                                              input logic [9:0] hi);
        logic [10:0] p11;
        logic [10:0] s11;
        p11 = {1'b0, pos};
        s11 = {1'b0, step};
        if (fwd) begin
            if (p11 + s11 >= {1'b0, hi}) axis_step = {1'b1, 1'b0, hi};
            else                         axis_step = {1'b0, 1'b1, pos + step};
        end else begin
            if (p11 <= {1'b0, lo} + s11) axis_step = {1'b1, 1'b1, lo};
            else                         axis_step = {1'b0, 1'b0, pos - step};
        end
    endfunction

    function automatic logic [9:0] clamp(input logic [9:0] v,
                                         input logic [9:0] lo,
                                         input logic [9:0] hi);
        if (v < lo)      clamp = lo;
        else if (v > hi) clamp = hi;
        else             clamp = v;
    endfunction

    state_t     r_state;
    logic       r_prev_match;
    logic [7:0] r_frame_cnt;
    logic [9:0] r_box_x, r_box_y;
    logic       r_dir_right, r_dir_down;
    logic [9:0] r_nx_x, r_nx_y;       // pending position (update or load)
    logic       r_nx_dr, r_nx_dd;     // pending directions
    logic       r_bx, r_by;           // pending wall hits
    logic [1:0] r_bounce;
    logic       r_strobe;

    logic        w_match;
    logic        w_tick;
    logic [9:0]  w_step;
    logic [11:0] w_x_res;
    logic [11:0] w_y_res;

    // Counters parked at (1,1) must give only one tick, so the edge of the
    // match is used rather than the level.
    assign w_match = (h_count == 10'd1) && (v_count == 10'd1);
    assign w_tick  = w_match && !r_prev_match;
    assign w_step  = {8'd0, speed} + 10'd1;
    assign w_x_res = axis_step(r_box_x, r_dir_right, w_step, L_MIN_X, L_MAX_X);
    assign w_y_res = axis_step(r_box_y, r_dir_down,  w_step, L_MIN_Y, L_MAX_Y);

    // A tick wins over a load in the same cycle. The host keeps load_valid high.
    assign load_ready = (r_state == IDLE) && !w_tick;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_prev_match <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_box_x      <= L_INIT_X;
            r_box_y      <= L_INIT_Y;
            r_dir_right  <= 1'b1;
            r_dir_down   <= 1'b1;
            r_nx_x       <= L_INIT_X;
            r_nx_y       <= L_INIT_Y;
            r_nx_dr      <= 1'b1;
            r_nx_dd      <= 1'b1;
            r_bx         <= 1'b0;
            r_by         <= 1'b0;
            r_bounce     <= 2'b00;
            r_strobe     <= 1'b0;
        end else begin
            r_prev_match <= w_match;
            if (w_tick) r_frame_cnt <= r_frame_cnt + 8'd1;
            r_strobe <= 1'b0;
            r_bounce <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        if (!pause) r_state <= UPD_X;
                    end else if (load_valid) begin
                        r_nx_x  <= clamp(load_x, L_MIN_X, L_MAX_X);
                        r_nx_y  <= clamp(load_y, L_MIN_Y, L_MAX_Y);
                        r_state <= LOAD;
                    end
                end
                UPD_X: begin
                    r_nx_x  <= w_x_res[9:0];
                    r_nx_dr <= w_x_res[10];
                    r_bx    <= w_x_res[11];
                    r_state <= UPD_Y;
                end
                UPD_Y: begin
                    r_nx_y  <= w_y_res[9:0];
                    r_nx_dd <= w_y_res[10];
                    r_by    <= w_y_res[11];
                    r_state <= COMMIT;
                end
                COMMIT: begin
                    r_box_x     <= r_nx_x;
                    r_box_y     <= r_nx_y;
                    r_dir_right <= r_nx_dr;
                    r_dir_down  <= r_nx_dd;
                    r_strobe    <= 1'b1;
                    r_bounce    <= {r_by, r_bx};
                    r_state     <= IDLE;
                end
                LOAD: begin
                    r_box_x <= r_nx_x;
                    r_box_y <= r_nx_y;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign box_x         = r_box_x;
    assign box_y         = r_box_y;
    assign dir_right     = r_dir_right;
    assign dir_down      = r_dir_down;
    assign bounce        = r_bounce;
    assign update_strobe = r_strobe;
    assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_box_motion_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for box_motion_ctrl. A behavioural model tracks position,
// direction and frame count from the motion rules. Every cycle it is compared
// with the DUT. Directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_box_motion_ctrl;

    localparam int MIN_X = 144;
    localparam int MIN_Y = 36;
    localparam int MAX_X = 747;
    localparam int MAX_Y = 463;

    logic       clk_25 = 1'b0;
    logic       rst_n  = 1'b0;
    logic [9:0] h_count = '0, v_count = '0;
    logic       pause = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       load_valid = 1'b0;
    logic [9:0] load_x = '0, load_y = '0;
    logic       load_ready;
    logic [9:0] box_x, box_y;
    logic       dir_right, dir_down;
    logic [1:0] bounce;
    logic       update_strobe;
    logic [7:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk_25 = ~clk_25;

    box_motion_ctrl dut (
        .clk_25(clk_25), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
        .pause(pause), .speed(speed), .load_valid(load_valid),
        .load_x(load_x), .load_y(load_y), .load_ready(load_ready),
        .box_x(box_x), .box_y(box_y), .dir_right(dir_right), .dir_down(dir_down),
        .bounce(bounce), .update_strobe(update_strobe), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_x = MIN_X, m_y = MIN_Y, m_fc = 0;
    bit  m_dr = 1, m_dd = 1;
    bit  m_prev = 0;
    int  m_age = 0;          // cycles elapsed since an accepted motion tick (0 = none)
    bit  m_load = 0;         // a load was accepted and lands on the next edge
    int  m_px, m_py;         // pending position
    bit  m_pdr, m_pdd, m_pbx, m_pby;
    bit  m_strobe = 0;
    bit [1:0] m_bounce = 0;
    bit  m_match, m_tick;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // One wall-bounce step along an axis, computed with plain integers.
    task automatic mstep(input int pos, input bit fwd, input int s, input int lo, input int hi,
                         output int np, output bit nd, output bit hit);
        if (fwd) begin
            if (pos + s >= hi) begin np = hi; nd = 0; hit = 1; end
            else               begin np = pos + s; nd = 1; hit = 0; end
        end else begin
            if (pos <= lo + s) begin np = lo; nd = 1; hit = 1; end
            else               begin np = pos - s; nd = 0; hit = 0; end
        end
    endtask

    always @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            m_x = MIN_X; m_y = MIN_Y; m_dr = 1; m_dd = 1; m_fc = 0;
            m_prev = 0; m_age = 0; m_load = 0; m_strobe = 0; m_bounce = 0;
        end else begin
            m_match  = (h_count == 1) && (v_count == 1);
            m_tick   = m_match && !m_prev;
            m_prev   = m_match;
            m_strobe = 0;
            m_bounce = 0;
            if (m_tick) m_fc = (m_fc + 1) % 256;
            if (m_age == 1) begin           // X is stepped with speed seen one cycle after the tick
                mstep(m_x, m_dr, int'(speed) + 1, MIN_X, MAX_X, m_px, m_pdr, m_pbx);
                m_age = 2;
            end else if (m_age == 2) begin  // Y is stepped with speed seen two cycles after the tick
                mstep(m_y, m_dd, int'(speed) + 1, MIN_Y, MAX_Y, m_py, m_pdd, m_pby);
                m_age = 3;
            end else if (m_age == 3) begin  // result visible 4 cycles after the tick
                m_x = m_px; m_y = m_py; m_dr = m_pdr; m_dd = m_pdd;
                m_strobe = 1; m_bounce = {m_pby, m_pbx};
                m_age = 0;
            end else if (m_load) begin
                m_x = m_px; m_y = m_py; m_load = 0;
            end else if (m_tick) begin
                if (!pause) m_age = 1;
            end else if (load_valid) begin
                m_load = 1;
                m_px = clampi(int'(load_x), MIN_X, MAX_X);
                m_py = clampi(int'(load_y), MIN_Y, MAX_Y);
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk_25) begin
        #1;
        chk("box_x", box_x, m_x);
        chk("box_y", box_y, m_y);
        chk("dir_right", dir_right, m_dr);
        chk("dir_down", dir_down, m_dd);
        chk("frame_cnt", frame_cnt, m_fc);
        chk("update_strobe", update_strobe, m_strobe);
        chk("bounce", bounce, m_bounce);
        chk("load_ready", load_ready,
            (m_age == 0 && !m_load && !((h_count == 1) && (v_count == 1) && !m_prev)) ? 1 : 0);
    end

    // ---------------- stimulus ----------------
    task automatic do_tick();
        @(negedge clk_25); h_count = 10'd1; v_count = 10'd1;
        @(negedge clk_25); h_count = 10'd0; v_count = 10'd0;
    endtask

    // Tick that must update: strobe low 3 cycles after, high 4 cycles after.
    task automatic tick_upd();
        do_tick();
        @(negedge clk_25);
        @(negedge clk_25); #2 chk("strobe_pre", update_strobe, 0);
        @(negedge clk_25); #2 chk("strobe_at4", update_strobe, 1);
    endtask

    task automatic do_load(input int x, input int y);
        @(negedge clk_25);
        load_valid = 1'b1; load_x = 10'(x); load_y = 10'(y);
        #1;
        for (int n = 0; n < 20 && !load_ready; n++) begin
            @(negedge clk_25); #1;
        end
        if (!load_ready) begin
            tests++; fails++;
            $display("FAIL load_timeout: got ready=0, expected ready=1");
        end
        @(negedge clk_25); load_valid = 1'b0;
        @(negedge clk_25); #2;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_25);
        #2;
        chk("rst_box_x", box_x, 144);
        chk("rst_box_y", box_y, 36);
        chk("rst_dirs", {dir_right, dir_down}, 2'b11);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_strobe", update_strobe, 0);
        @(negedge clk_25); rst_n = 1'b1;
        repeat (2) @(negedge clk_25);

        // first step from reset
        tick_upd();
        chk("t1_x", box_x, 145); chk("t1_y", box_y, 37);
        chk("t1_bounce", bounce, 0); chk("t1_fc", frame_cnt, 1);

        // corner bounce
        do_load(746, 462);
        chk("ld1_x", box_x, 746); chk("ld1_y", box_y, 462);
        tick_upd();
        chk("corner_x", box_x, 747); chk("corner_y", box_y, 463);
        chk("corner_bounce", bounce, 2'b11);
        chk("corner_dirs", {dir_right, dir_down}, 2'b00);
        tick_upd();
        chk("back_x", box_x, 746); chk("back_y", box_y, 462);
        chk("back_bounce", bounce, 0);

        // clamping loads
        do_load(900, 5);
        chk("clamp1_x", box_x, 747); chk("clamp1_y", box_y, 36);
        do_load(0, 1023);
        chk("clamp2_x", box_x, 144); chk("clamp2_y", box_y, 463);

        // load request in the same cycle as a tick
        @(negedge clk_25);
        h_count = 10'd1; v_count = 10'd1;
        load_valid = 1'b1; load_x = 10'd300; load_y = 10'd200;
        #1 chk("collide_ready", load_ready, 0);
        @(negedge clk_25); h_count = 10'd0; v_count = 10'd0;
        #1;
        for (n = 0; n < 20 && !load_ready; n++) begin
            @(negedge clk_25); #1;
        end
        chk("collide_wait", n, 3);
        @(negedge clk_25); load_valid = 1'b0;
        @(negedge clk_25); #2;
        chk("collide_x", box_x, 300); chk("collide_y", box_y, 200);
        chk("collide_fc", frame_cnt, 4);

        // pause: three ticks, no motion
        pause = 1'b1;
        repeat (3) begin do_tick(); repeat (2) @(negedge clk_25); end
        #2;
        chk("pause_x", box_x, 300); chk("pause_y", box_y, 200);
        chk("pause_fc", frame_cnt, 7);
        pause = 1'b0;

        // counters parked at (1,1) for 5 cycles -> a single tick
        @(negedge clk_25); h_count = 10'd1; v_count = 10'd1;
        repeat (4) @(negedge clk_25);
        @(negedge clk_25); h_count = 10'd0; v_count = 10'd0;
        repeat (4) @(negedge clk_25);
        #2;
        chk("hold_fc", frame_cnt, 8);
        chk("hold_x", box_x, 301); chk("hold_y", box_y, 199);

        // fastest speed into the right wall
        do_load(740, 100);
        speed = 2'd3;
        tick_upd();
        chk("fast1_x", box_x, 744); chk("fast1_y", box_y, 96);
        tick_upd();
        chk("fast2_x", box_x, 747); chk("fast2_bx", bounce[0], 1);
        chk("fast2_dr", dir_right, 0);

        // reset while the update sequence is in its Y step
        speed = 2'd0;
        do_tick();
        @(negedge clk_25);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_x", box_x, 144); chk("mid_rst_y", box_y, 36);
        chk("mid_rst_strobe", update_strobe, 0);
        repeat (2) @(negedge clk_25);
        rst_n = 1'b1;
        repeat (6) @(negedge clk_25);
        #2;
        chk("post_rst_fc", frame_cnt, 0);
        chk("post_rst_x", box_x, 144);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/box_motion_ctrl.md
Name: box_motion_ctrl

Overview:
- Per-frame motion controller for the bouncing box drawn by the pixel renderer.
- Detects the frame tick from the VGA counters and sequences the box X/Y update through a small FSM.
- Handles wall bounces, speed and pause, and accepts host repositioning through a valid/ready load handshake.
- Its box_x/box_y outputs feed the renderer's box comparators directly.

Parameters:
- BOX_W, 36, box width in pixels
- BOX_H, 36, box height in pixels
- PORCH_L, 144, leftmost visible column
- PORCH_R, 784, first column right of the visible area
- PORCH_T, 36, topmost visible row
- PORCH_B, 500, first row below the visible area
- INIT_X, 144, box_x value after reset
- INIT_Y, 36, box_y value after reset

Ports:
- clk_25  in  1  pixel clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- h_count  in  10  horizontal pixel counter
- v_count  in  10  vertical line counter
- pause  in  1  freezes motion while high
- speed  in  2  step size per frame = speed+1 pixels
- load_valid  in  1  host repositioning request
- load_x  in  10  requested X
- load_y  in  10  requested Y
- load_ready  out  1  load accepted when load_valid and load_ready are both high
- box_x  out  10  box left edge
- box_y  out  10  box top edge
- dir_right  out  1  1 = moving right
- dir_down  out  1  1 = moving down
- bounce  out  2  one-cycle pulse; [0] = X wall hit, [1] = Y wall hit
- update_strobe  out  1  one-cycle pulse after each committed motion update
- frame_cnt  out  8  frame tick counter

Behaviour:
- Reset (async, rst_n=0):
  - box_x=INIT_X, box_y=INIT_Y, dir_right=1, dir_down=1.
  - bounce=0, update_strobe=0, frame_cnt=0, FSM=IDLE.
  - Any in-flight update is discarded with no strobe.
- Limits: MAX_X = PORCH_R-1-BOX_W (747); MAX_Y = PORCH_B-1-BOX_H (463). Arithmetic uses 11 bits internally; no wrap.
- Tick:
  - tick is high in the first cycle where h_count==1 and v_count==1.
  - A registered previous-match flag stops counts held at (1,1) from producing more than one tick.
- frame_cnt increments on every tick, including while paused, and wraps from 255 to 0.
- FSM states: IDLE, UPD_X, UPD_Y, COMMIT, LOAD.
- IDLE transitions:
  - On tick with pause=0, go to UPD_X.
  - On tick with pause=1, stay in IDLE; no motion, no strobe.
  - Otherwise, a load handshake goes to LOAD.
- load_ready = (state==IDLE) and not tick. Tick beats load in the same cycle; load_valid must be held by the host.
- UPD_X (step s = speed+1, sampled in this state):
  - Moving right: if box_x+s >= MAX_X, next_x = MAX_X, flip direction, set bx. Otherwise next_x = box_x+s.
  - Moving left: if box_x <= PORCH_L+s, next_x = PORCH_L, flip direction, set bx. Otherwise next_x = box_x-s.
  - Then go to UPD_Y.
- UPD_Y: same rule using box_y, MAX_Y, PORCH_T and dir_down, setting by. Then go to COMMIT.
- COMMIT:
  - box_x, box_y, dir_right and dir_down update together on the closing edge.
  - The following cycle has update_strobe=1 and bounce={by,bx}.
  - Return to IDLE.
- Latency: tick in cycle C0 gives new positions visible from C4; update_strobe and bounce are high in C4 only.
- A tick arriving during UPD_X/UPD_Y/COMMIT still increments frame_cnt but does not start another update.
- LOAD (one cycle):
  - box_x = clamp(load_x, PORCH_L, MAX_X); box_y = clamp(load_y, PORCH_T, MAX_Y).
  - Directions are unchanged, no strobe, return to IDLE.
- speed or pause changing mid-update has no effect until the next tick, except that speed is sampled in UPD_X and UPD_Y.

Test Plan:
- Reset, speed=0, one tick -> box (145,37); update_strobe high exactly 4 cycles after the tick cycle; bounce=00; frame_cnt=1.
- Load (746,462), speed=0, tick -> box (747,463); bounce=2'b11; dir_right=0; dir_down=0. Next tick -> (746,462), bounce=00.
- Load x=900, y=5 -> box (747,36). Load x=0, y=1023 -> box (144,463). No update_strobe either time.
- load_valid high in the same cycle as a tick -> load_ready=0 that cycle; load accepted only after COMMIT returns to IDLE; final position = clamped load value.
- pause=1 for 3 ticks -> box unchanged, no strobe, frame_cnt +3. Counts held at (1,1) for 5 cycles -> single tick.
- speed=3 from box_x=740 moving right -> box_x=747, bounce[0]=1. rst_n low during UPD_Y -> reset values, no strobe.
